// File: rtl/conv_window_gen_pkg.sv
// Shared constants, state encoding and window bit-layout helper for the
// 3x3 convolution window generator.
package conv_window_gen_pkg;

    localparam int IMG_W   = 28;
    localparam int K       = 3;
    localparam int PIX_W   = 8;
    localparam int N_COL   = IMG_W - K + 1;
    localparam int TIMEOUT = 8;

    localparam int LANE_W  = K * PIX_W;
    localparam int WIN_W   = K * K * PIX_W;
    localparam int ADDR_W  = 7;
    localparam int COL_W   = 5;
    localparam int TMO_W   = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_OUT   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COL - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // Bit offset of the pixel at window row r, column c.
    function automatic int win_offset(input int r, input int c);
        return PIX_W * (K * r + c);
    endfunction

endpackage

// File: rtl/conv_window_gen_lane_capture.sv
// One line-buffer lane: holds the most recent word returned for the current
// read request and a flag saying it has arrived.
module conv_window_gen_lane_capture
    import conv_window_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [LANE_W-1:0] rd_data,
    output logic [LANE_W-1:0] data,
    output logic              captured
);

    logic [LANE_W-1:0] data_r;
    logic              flag_r;

    // Capture register: a new request drops the flag, an arriving word sets it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r <= '0;
            flag_r <= 1'b0;
        end else if (clear) begin
            data_r <= data_r;
            flag_r <= 1'b0;
        end else if (load) begin
            data_r <= rd_data;
            flag_r <= 1'b1;
        end else begin
            data_r <= data_r;
            flag_r <= flag_r;
        end
    end

    // Forward a word arriving this cycle so the window completes without an extra wait.
    always_comb begin
        data     = data_r;
        captured = flag_r;
        if (load) begin
            data     = rd_data;
            captured = 1'b1;
        end else begin
            data     = data_r;
            captured = flag_r;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Sweeps a shared read address across three line buffers, gathers the three
// returned lanes into a 3x3 window and hands each window to the MAC stage.
module conv_window_gen
    import conv_window_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              row_done,
    output logic              err,
    output logic              lb_rd_en,
    output logic [ADDR_W-1:0] lb_rd_addr,
    input  logic [LANE_W-1:0] lb0_rd_data,
    input  logic [LANE_W-1:0] lb1_rd_data,
    input  logic [LANE_W-1:0] lb2_rd_data,
    input  logic              lb0_data_valid,
    input  logic              lb1_data_valid,
    input  logic              lb2_data_valid,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [WIN_W-1:0]  win_data,
    output logic [COL_W-1:0]  win_col
);

    state_t            state_r, state_s;
    logic [COL_W-1:0]  col_r, col_s, col_inc_s;
    logic [TMO_W-1:0]  tmo_r, tmo_s;
    logic              busy_r, busy_s;
    logic              row_done_r, row_done_s;
    logic              err_r, err_s;
    logic              rd_en_r, rd_en_s;
    logic [ADDR_W-1:0] rd_addr_r, rd_addr_s;
    logic              win_valid_r, win_valid_s;
    logic [WIN_W-1:0]  win_data_r, win_data_s;
    logic [COL_W-1:0]  win_col_r, win_col_s;

    logic [LANE_W-1:0] lane_rd_data_s [K];
    logic [LANE_W-1:0] lane_data_s [K];
    logic [K-1:0]      lane_valid_s;
    logic [K-1:0]      lane_load_s;
    logic [K-1:0]      lane_captured_s;
    logic              lane_clear_s;
    logic              all_captured_s;
    logic [WIN_W-1:0]  window_s;

    assign lane_rd_data_s[0] = lb0_rd_data;
    assign lane_rd_data_s[1] = lb1_rd_data;
    assign lane_rd_data_s[2] = lb2_rd_data;
    assign lane_valid_s      = {lb2_data_valid, lb1_data_valid, lb0_data_valid};
    assign col_inc_s         = col_r + COL_W'(1);

    // Lanes are cleared when a request goes out and only listen while it is outstanding.
    always_comb begin
        lane_clear_s = (state_r == ST_ISSUE);
        if (state_r == ST_WAIT) begin
            lane_load_s = lane_valid_s;
        end else begin
            lane_load_s = '0;
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_lane
        conv_window_gen_lane_capture u_lane_capture (
            .clk      (clk),
            .rst      (rst),
            .clear    (lane_clear_s),
            .load     (lane_load_s[g]),
            .rd_data  (lane_rd_data_s[g]),
            .data     (lane_data_s[g]),
            .captured (lane_captured_s[g])
        );
    end

    assign all_captured_s = &lane_captured_s;

    // Place each lane's pixels into their row/column slots of the window word.
    always_comb begin
        window_s = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                window_s[win_offset(r, c) +: PIX_W] = lane_data_s[r][c*PIX_W +: PIX_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode: one request/collect/present loop per column.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (all_captured_s) begin
                    state_s = ST_OUT;
                end else if (tmo_r == TMO_LAST) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (!win_ready) begin
                    state_s = ST_OUT;
                end else if (col_r == COL_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of counters and registered outputs, computed ahead so every output is a flop.
    always_comb begin
        col_s       = col_r;
        tmo_s       = tmo_r;
        busy_s      = busy_r;
        row_done_s  = 1'b0;
        err_s       = err_r;
        rd_en_s     = 1'b0;
        rd_addr_s   = rd_addr_r;
        win_valid_s = win_valid_r;
        win_data_s  = win_data_r;
        win_col_s   = win_col_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    col_s     = '0;
                    busy_s    = 1'b1;
                    rd_en_s   = 1'b1;
                    rd_addr_s = '0;
                end else begin
                    busy_s    = busy_r;
                end
            end
            ST_ISSUE: begin
                tmo_s = '0;
            end
            ST_WAIT: begin
                if (all_captured_s) begin
                    win_data_s  = window_s;
                    win_col_s   = col_r;
                    win_valid_s = 1'b1;
                end else if (tmo_r == TMO_LAST) begin
                    err_s     = 1'b1;
                    rd_en_s   = 1'b1;
                    rd_addr_s = {{(ADDR_W-COL_W){1'b0}}, col_r};
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end
            ST_OUT: begin
                if (!win_ready) begin
                    win_valid_s = 1'b1;
                end else if (col_r == COL_LAST) begin
                    win_valid_s = 1'b0;
                    row_done_s  = 1'b1;
                end else begin
                    win_valid_s = 1'b0;
                    col_s       = col_inc_s;
                    rd_en_s     = 1'b1;
                    rd_addr_s   = {{(ADDR_W-COL_W){1'b0}}, col_inc_s};
                end
            end
            ST_DONE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s      = 1'b0;
                win_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_r       <= '0;
            tmo_r       <= '0;
            busy_r      <= 1'b0;
            row_done_r  <= 1'b0;
            err_r       <= 1'b0;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= '0;
            win_valid_r <= 1'b0;
            win_data_r  <= '0;
            win_col_r   <= '0;
        end else begin
            col_r       <= col_s;
            tmo_r       <= tmo_s;
            busy_r      <= busy_s;
            row_done_r  <= row_done_s;
            err_r       <= err_s;
            rd_en_r     <= rd_en_s;
            rd_addr_r   <= rd_addr_s;
            win_valid_r <= win_valid_s;
            win_data_r  <= win_data_s;
            win_col_r   <= win_col_s;
        end
    end

    assign busy       = busy_r;
    assign row_done   = row_done_r;
    assign err        = err_r;
    assign lb_rd_en   = rd_en_r;
    assign lb_rd_addr = rd_addr_r;
    assign win_valid  = win_valid_r;
    assign win_data   = win_data_r;
    assign win_col    = win_col_r;

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Downstream consumer of three line buffers holding the three most recent image rows: row 0 is the oldest/top row, row 2 the newest.
- Each line-buffer read returns three adjacent 8-bit pixels, so one shared read address across all three buffers yields a complete 3x3 window.
- The block sweeps the read address across one row, collects all three lanes and presents each window to the convolution MAC stage over a valid/ready handshake.
- One start pulse processes exactly one output row of windows.

Parameters:
- IMG_W, 28: pixels per line-buffer row.
- K, 3: kernel width/height, fixed by the 24-bit line-buffer read width.
- PIX_W, 8: bits per pixel.
- N_COL, IMG_W-K+1 (26): windows per row.
- TIMEOUT, 8: cycles allowed for all three lanes to return data before a reissue.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a row pass; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until row_done.
- row_done  out  1  one-cycle pulse after the last window is accepted.
- err  out  1  sticky; set on any lane timeout; cleared only by reset.
- lb_rd_en  out  1  read request, shared by the three line buffers.
- lb_rd_addr  out  7  read column, shared by the three line buffers.
- lb0_rd_data, lb1_rd_data, lb2_rd_data  in  24  lane read data; byte c is pixel at column addr+c.
- lb0_data_valid, lb1_data_valid, lb2_data_valid  in  1  per-lane one-cycle data strobes.
- win_valid  out  1  window available.
- win_ready  in  1  MAC stage accepts the window.
- win_data  out  72  bits [8*(3r+c)+7 : 8*(3r+c)] = row r, column c.
- win_col  out  5  output column index of the presented window, 0..25.

Behaviour:
- Reset (rst low, asynchronous): all of the following go to 0: state (IDLE), col counter, lane capture registers and flags, timeout counter, busy, row_done, err, lb_rd_en, lb_rd_addr, win_valid, win_data, win_col.
- Line-buffer contract:
  - The buffer samples rd_en only in its idle cycle.
  - data_valid pulses for one cycle, two cycles after the sampled rd_en.
  - The line-buffer producer is write-gated by busy, so no writes occur during a pass.
- IDLE: on start, clear col and err is left unchanged; go to ISSUE; busy rises next cycle.
- ISSUE (1 cycle):
  - lb_rd_en=1, lb_rd_addr=col.
  - Clear the lane-captured flags and the timeout counter.
  - Go to WAIT.
- WAIT:
  - lb_rd_en=0.
  - For each lane, when its data_valid is high, latch its rd_data into row-r capture and set flag r. A repeat valid on an already-captured lane overwrites it (same address, so same data).
  - When all three flags are set (including the cycle in which the last valid arrives), load win_data from the captures, set win_col=col and win_valid=1, and go to OUT.
  - If the timeout counter reaches TIMEOUT-1 without all three flags: set err and go to ISSUE (reissue the same col). Captured flags are discarded.
- OUT:
  - win_valid stays high; win_data and win_col are stable until the cycle where win_valid and win_ready are both high.
  - On acceptance: win_valid=0.
  - If col==N_COL-1: go to DONE.
  - Otherwise col=col+1 and go to ISSUE.
  - data_valid pulses arriving in OUT are ignored.
- DONE (1 cycle): row_done=1, busy=0 next cycle, return to IDLE.
- Throughput: one window every 4 cycles with win_ready held high (ISSUE, WAIT×2, OUT accept). A pass takes 26×4+1 = 105 cycles.
- Boundary rules:
  - start during busy: ignored, with no effect on col.
  - start in the DONE cycle: ignored.
  - win_ready low indefinitely: the block stalls in OUT with no further reads.
  - Reset asserted mid-pass: immediate return to reset values. Any line-buffer data_valid arriving after reset release in IDLE is ignored.
  - col never exceeds 25. lb_rd_addr+2 ≤ 27 always.

Decomposition:
- Shared package holds:
  - Parameters: IMG_W, K, PIX_W, N_COL.
  - State encoding localparams: IDLE, ISSUE, WAIT, OUT, DONE.
  - A function mapping (r, c) to the win_data bit offset.
- One natural sub-module, lane_capture: a per-lane data register plus captured flag, with clear and load inputs, instantiated three times.
- The FSM, counters and handshake stay in the top-level block.

Test Plan:
- Rows filled with pixel = 16·row+column (row 0: 0x00..0x1B), start, win_ready=1 → 26 windows. Window 0 has win_data bytes 00,01,02,10,11,12,20,21,22. Window 25 has 19,1A,1B,29,2A,2B,39,3A,3B. row_done pulses 105 cycles after start.
- Hold win_ready low for 10 cycles at window 5 → win_valid stays high, win_data/win_col (5) stable, no lb_rd_en pulses. On release, window 6 follows in 4 cycles.
- Lanes return valid skewed (lane 2 two cycles after lanes 0 and 1) → correct window, err=0.
- Suppress lane 1 valid for one request → after 8 cycles err=1 and lb_rd_en is reissued with the same addr. The window is correct once lane 1 returns.
- start pulsed while busy at window 10 → ignored: the sequence is unchanged and row_done occurs once.
- rst low mid-pass at window 12 → all outputs 0 immediately. A fresh start then restarts at win_col=0 with err=0.
